// File: rtl/isq_pkg.sv
// Shared types and helpers for the issue queue.
// The entry struct is sized by the package widths below. Keep the iq_array
// parameters at these values.
package isq_pkg;

  localparam int ISQ_PREG_W    = 6;
  localparam int ISQ_ROB_LOG   = 6;
  localparam int ISQ_PAYLOAD_W = 128;

  typedef struct packed {
    logic                     valid;
    logic                     busy1;
    logic                     busy2;
    logic [ISQ_PREG_W-1:0]    prs1;
    logic [ISQ_PREG_W-1:0]    prs2;
    logic                     robidx_flag;
    logic [ISQ_ROB_LOG-1:0]   robidx;
    logic [ISQ_PAYLOAD_W-1:0] payload;
  } isq_entry_t;

  // A is older than B. The wrap flag flips each time the ROB index wraps, so
  // differing flags invert the plain index comparison.
  function automatic logic is_older(input logic                   flag_a,
                                    input logic [ISQ_ROB_LOG-1:0] idx_a,
                                    input logic                   flag_b,
                                    input logic [ISQ_ROB_LOG-1:0] idx_b);
    if (flag_a == flag_b) return (idx_a < idx_b);
    else                  return (idx_a > idx_b);
  endfunction

endpackage

// File: rtl/iq_age_select.sv
// Oldest-ready select over DEPTH entries: one-hot grant plus any-ready.
module iq_age_select
  import isq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ROB_LOG = 6
) (
  input  logic [DEPTH-1:0]         ready,
  input  logic [DEPTH-1:0]         age_flag,
  input  logic [DEPTH*ROB_LOG-1:0] age_idx,
  output logic [DEPTH-1:0]         grant,
  output logic                     any_ready
);

  assign any_ready = |ready;

  // An entry wins when no other ready entry is older. Equal ages cannot occur
  // in normal operation; if they did, the lower index wins so grant stays one-hot.
  always_comb begin
    logic win;
    grant = '0;
    win   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      win = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j]) begin
          if (j < i) begin
            if (!is_older(age_flag[i], age_idx[i*ROB_LOG +: ROB_LOG],
                          age_flag[j], age_idx[j*ROB_LOG +: ROB_LOG]))
              win = 1'b0;
          end else begin
            if (is_older(age_flag[j], age_idx[j*ROB_LOG +: ROB_LOG],
                         age_flag[i], age_idx[i*ROB_LOG +: ROB_LOG]))
              win = 1'b0;
          end
        end
      end
      grant[i] = win;
    end
  end

endmodule

// File: rtl/iq_array.sv
// Issue queue entry array: enqueue into the lowest free slot, wakeup by
// writeback tag broadcast, oldest-ready issue, and flush of younger entries.
// Optional feature macro ISQ_ENQ_BYPASS_WAKEUP_EN: when defined, a source
// that matches a same-cycle writeback is stored as not busy at enqueue.
module iq_array
  import isq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PREG_W    = 6,
  parameter int WB_PORTS  = 2,
  parameter int ROB_LOG   = 6,
  parameter int PAYLOAD_W = 128
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [PAYLOAD_W-1:0]       enq_payload,
  input  logic [PREG_W-1:0]          enq_prs1,
  input  logic [PREG_W-1:0]          enq_prs2,
  input  logic                       enq_src1_busy,
  input  logic                       enq_src2_busy,
  input  logic                       enq_robidx_flag,
  input  logic [ROB_LOG-1:0]         enq_robidx,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0] wb_prd,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [PAYLOAD_W-1:0]       issue_payload,
  output logic [PREG_W-1:0]          issue_prs1,
  output logic [PREG_W-1:0]          issue_prs2,
  output logic                       issue_robidx_flag,
  output logic [ROB_LOG-1:0]         issue_robidx,
  input  logic                       flush_valid,
  input  logic                       flush_robidx_flag,
  input  logic [ROB_LOG-1:0]         flush_robidx,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  isq_entry_t               ent_q [DEPTH];
  isq_entry_t               ent_d [DEPTH];

  logic [DEPTH-1:0]         wake1;
  logic [DEPTH-1:0]         wake2;
  logic                     enq_wake1;
  logic                     enq_wake2;
  logic [DEPTH-1:0]         rdy;
  logic [DEPTH-1:0]         age_flag;
  logic [DEPTH*ROB_LOG-1:0] age_idx;
  logic [DEPTH-1:0]         grant;
  logic                     any_ready;
  logic [IDX_W-1:0]         free_idx;
  logic [IDX_W-1:0]         iss_idx;
  logic [CNT_W-1:0]         cnt;
  logic                     enq_fire;
  logic                     issue_fire;

  // Valid-entry popcount from the registered valid bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + CNT_W'(ent_q[i].valid);
  end

  assign count      = cnt;
  assign enq_ready  = (cnt < CNT_W'(DEPTH)) && !flush_valid;
  assign enq_fire   = enq_valid && enq_ready;
  assign issue_valid = any_ready;
  assign issue_fire = any_ready && issue_ready;

  // Lowest-index free slot; scanning downward leaves the lowest one last.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!ent_q[i].valid) free_idx = IDX_W'(i);
  end

  // Tag match of every stored source against all writeback ports.
  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_valid[k] && wb_prd[k*PREG_W +: PREG_W] == ent_q[i].prs1) wake1[i] = 1'b1;
        if (wb_valid[k] && wb_prd[k*PREG_W +: PREG_W] == ent_q[i].prs2) wake2[i] = 1'b1;
      end
    end
  end

`ifdef ISQ_ENQ_BYPASS_WAKEUP_EN
  // Same-cycle writeback match on the incoming sources.
  always_comb begin
    enq_wake1 = 1'b0;
    enq_wake2 = 1'b0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb_valid[k] && wb_prd[k*PREG_W +: PREG_W] == enq_prs1) enq_wake1 = 1'b1;
      if (wb_valid[k] && wb_prd[k*PREG_W +: PREG_W] == enq_prs2) enq_wake2 = 1'b1;
    end
  end
`else
  assign enq_wake1 = 1'b0;
  assign enq_wake2 = 1'b0;
`endif

  // Readiness uses registered busy bits only, so a wakeup counts next cycle.
  always_comb begin
    rdy      = '0;
    age_flag = '0;
    age_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i]                        = ent_q[i].valid && !ent_q[i].busy1 && !ent_q[i].busy2;
      age_flag[i]                   = ent_q[i].robidx_flag;
      age_idx[i*ROB_LOG +: ROB_LOG] = ent_q[i].robidx;
    end
  end

  iq_age_select #(
    .DEPTH   (DEPTH),
    .ROB_LOG (ROB_LOG)
  ) u_age_select (
    .ready     (rdy),
    .age_flag  (age_flag),
    .age_idx   (age_idx),
    .grant     (grant),
    .any_ready (any_ready)
  );

  // One-hot grant to index for the issue output mux.
  always_comb begin
    iss_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (grant[i]) iss_idx = IDX_W'(i);
  end

  assign issue_payload     = ent_q[iss_idx].payload;
  assign issue_prs1        = ent_q[iss_idx].prs1;
  assign issue_prs2        = ent_q[iss_idx].prs2;
  assign issue_robidx_flag = ent_q[iss_idx].robidx_flag;
  assign issue_robidx      = ent_q[iss_idx].robidx;

  // Next entry state: wakeup, flush of strictly younger entries, issue, then
  // enqueue. Enqueue only targets a free slot and is blocked during flush, so
  // it never collides with the kill paths.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (wake1[i]) ent_d[i].busy1 = 1'b0;
      if (wake2[i]) ent_d[i].busy2 = 1'b0;
      if (flush_valid && ent_q[i].valid &&
          is_older(flush_robidx_flag, flush_robidx,
                   ent_q[i].robidx_flag, ent_q[i].robidx))
        ent_d[i].valid = 1'b0;
      if (issue_fire && grant[i]) ent_d[i].valid = 1'b0;
    end
    if (enq_fire) begin
      ent_d[free_idx].valid       = 1'b1;
      ent_d[free_idx].busy1       = enq_src1_busy && !enq_wake1;
      ent_d[free_idx].busy2       = enq_src2_busy && !enq_wake2;
      ent_d[free_idx].prs1        = enq_prs1;
      ent_d[free_idx].prs2        = enq_prs2;
      ent_d[free_idx].robidx_flag = enq_robidx_flag;
      ent_d[free_idx].robidx      = enq_robidx;
      ent_d[free_idx].payload     = enq_payload;
    end
  end

  // Entry registers; reset clears only the valid bits and overrides all updates.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule
